// File: rtl/div_cluster_if.sv
// rtl/div_cluster_if.sv - divide request and tagged result bundle for div_cluster
interface div_cluster_if #(
    parameter int WIDTH       = 32,
    parameter int RS_ID_WIDTH = 5
);
    logic                   input_valid;
    logic                   input_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_in;
    logic [4:0]             result_reg_addr_in;
    logic [WIDTH-1:0]       op1;
    logic [WIDTH-1:0]       op2;
    logic                   is_signed;
    logic                   oe_in;
    logic                   rc_in;
    logic                   output_valid;
    logic                   output_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_out;
    logic [4:0]             result_reg_addr_out;
    logic [WIDTH-1:0]       result;
    logic                   ov_out;
    logic                   oe_out;
    logic                   rc_out;
    logic                   cr_lt;
    logic                   cr_gt;
    logic                   cr_eq;

    modport master (
        output input_valid, rs_id_in, result_reg_addr_in, op1, op2, is_signed, oe_in, rc_in,
        output output_ready,
        input  input_ready, output_valid, rs_id_out, result_reg_addr_out, result,
        input  ov_out, oe_out, rc_out, cr_lt, cr_gt, cr_eq
    );

    modport slave (
        input  input_valid, rs_id_in, result_reg_addr_in, op1, op2, is_signed, oe_in, rc_in,
        input  output_ready,
        output input_ready, output_valid, rs_id_out, result_reg_addr_out, result,
        output ov_out, oe_out, rc_out, cr_lt, cr_gt, cr_eq
    );
endinterface

// File: rtl/div_cluster.sv
// rtl/div_cluster.sv - pool of radix-2 restoring dividers with an out-of-order tagged result port
// Optional DIV_EARLY_OUT_EN: skip iteration when the quotient is trivially zero or the op overflows.
module div_cluster #(
    parameter int WIDTH       = 32,
    parameter int ENGINES     = 2,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    div_cluster_if.slave bus
);
    localparam int IW = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    // dvd holds the raw dividend, then |dividend| shifting out while quotient bits shift in
    state_t                 st   [ENGINES];
    logic [WIDTH-1:0]       dvd  [ENGINES];
    logic [WIDTH-1:0]       dvs  [ENGINES];
    logic [WIDTH-1:0]       rem  [ENGINES];
    logic [CW-1:0]          cnt  [ENGINES];
    logic [RS_ID_WIDTH-1:0] tag  [ENGINES];
    logic [4:0]             gpr  [ENGINES];
    logic [2:0]             cr   [ENGINES];
    logic [ENGINES-1:0]     sgn, neg, ov, oe, rc;

    logic [WIDTH:0]         trial [ENGINES];
    logic [WIDTH:0]         diff  [ENGINES];
    logic [WIDTH-1:0]       abs1  [ENGINES];
    logic [WIDTH-1:0]       abs2  [ENGINES];
    logic [WIDTH-1:0]       qfix  [ENGINES];
    logic [ENGINES-1:0]     ov_now;

    logic [ENGINES-1:0]     idle_mask, cand_mask, rot_mask;
    logic [IW-1:0]          free_idx, rr_q, rr_next, sel_q, pick_idx;
    logic [IW:0]            pick_sum;
    logic                   pick_any, out_valid_q, accept, out_fire;

    logic [RS_ID_WIDTH-1:0] o_tag;
    logic [4:0]             o_gpr;
    logic [WIDTH-1:0]       o_res;
    logic [2:0]             o_cr;
    logic                   o_ov, o_oe, o_rc;

    always_comb begin
        for (int i = 0; i < ENGINES; i++) begin
            trial[i]  = {rem[i], dvd[i][WIDTH-1]};
            diff[i]   = trial[i] - {1'b0, dvs[i]};
            abs1[i]   = (sgn[i] && dvd[i][WIDTH-1]) ? -dvd[i] : dvd[i];
            abs2[i]   = (sgn[i] && dvs[i][WIDTH-1]) ? -dvs[i] : dvs[i];
            qfix[i]   = ov[i] ? '0 : (neg[i] ? -dvd[i] : dvd[i]);
            ov_now[i] = (dvs[i] == '0) || (sgn[i] && (dvd[i] == MIN_NEG) && (dvs[i] == '1));
        end
    end

    // The engine currently parked in the output register is never a candidate again.
    always_comb begin
        idle_mask = '0;
        cand_mask = '0;
        free_idx  = '0;
        for (int i = ENGINES - 1; i >= 0; i--) begin
            idle_mask[i] = (st[i] == IDLE);
            cand_mask[i] = (st[i] == DONE) && !(out_valid_q && (sel_q == IW'(i)));
            if (st[i] == IDLE) free_idx = IW'(i);
        end
        out_fire = out_valid_q && bus.output_ready;
        accept   = bus.input_valid && (|idle_mask);
        rr_next  = rr_q;
        if (out_fire) rr_next = (sel_q == IW'(ENGINES - 1)) ? '0 : sel_q + 1'b1;
        rot_mask = ENGINES'({cand_mask, cand_mask} >> rr_next);
        pick_any = 1'b0;
        pick_sum = '0;
        for (int k = ENGINES - 1; k >= 0; k--) begin
            if (rot_mask[k]) begin
                pick_any = 1'b1;
                pick_sum = {1'b0, rr_next} + (IW+1)'(k);
                if (pick_sum >= (IW+1)'(ENGINES)) pick_sum = pick_sum - (IW+1)'(ENGINES);
            end
        end
        pick_idx = pick_sum[IW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENGINES; i++) begin
                st[i]  <= IDLE;
                dvd[i] <= '0;
                dvs[i] <= '0;
                rem[i] <= '0;
                cnt[i] <= '0;
                tag[i] <= '0;
                gpr[i] <= '0;
                cr[i]  <= '0;
            end
            sgn         <= '0;
            neg         <= '0;
            ov          <= '0;
            oe          <= '0;
            rc          <= '0;
            rr_q        <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            o_tag       <= '0;
            o_gpr       <= '0;
            o_res       <= '0;
            o_cr        <= '0;
            o_ov        <= 1'b0;
            o_oe        <= 1'b0;
            o_rc        <= 1'b0;
        end else begin
            for (int i = 0; i < ENGINES; i++) begin
                case (st[i])
                    IDLE: if (accept && (free_idx == IW'(i))) begin
                        st[i]  <= PREP;
                        dvd[i] <= bus.op1;
                        dvs[i] <= bus.op2;
                        tag[i] <= bus.rs_id_in;
                        gpr[i] <= bus.result_reg_addr_in;
                        sgn[i] <= bus.is_signed;
                        oe[i]  <= bus.oe_in;
                        rc[i]  <= bus.rc_in;
                    end
                    PREP: begin
                        ov[i]  <= ov_now[i];
                        neg[i] <= sgn[i] && (dvd[i][WIDTH-1] ^ dvs[i][WIDTH-1]);
                        dvd[i] <= abs1[i];
                        dvs[i] <= abs2[i];
                        rem[i] <= '0;
                        cnt[i] <= CW'(WIDTH - 1);
                        st[i]  <= ITER;
`ifdef DIV_EARLY_OUT_EN
                        if (ov_now[i] || (abs1[i] < abs2[i])) begin
                            dvd[i] <= '0;
                            st[i]  <= FIX;
                        end
`endif
                    end
                    ITER: begin
                        dvd[i] <= {dvd[i][WIDTH-2:0], !diff[i][WIDTH]};
                        rem[i] <= diff[i][WIDTH] ? trial[i][WIDTH-1:0] : diff[i][WIDTH-1:0];
                        cnt[i] <= cnt[i] - 1'b1;
                        if (cnt[i] == '0) st[i] <= FIX;
                    end
                    FIX: begin
                        dvd[i] <= qfix[i];
                        cr[i]  <= {qfix[i][WIDTH-1], !qfix[i][WIDTH-1] && (qfix[i] != '0), qfix[i] == '0};
                        st[i]  <= DONE;
                    end
                    DONE: if (out_fire && (sel_q == IW'(i))) st[i] <= IDLE;
                    default: st[i] <= IDLE;
                endcase
            end

            // Output register only reloads when empty or being drained, which locks the selection.
            if (!out_valid_q || bus.output_ready) begin
                rr_q        <= rr_next;
                out_valid_q <= pick_any;
                sel_q       <= pick_idx;
                o_tag       <= pick_any ? tag[pick_idx] : '0;
                o_gpr       <= pick_any ? gpr[pick_idx] : '0;
                o_res       <= pick_any ? dvd[pick_idx] : '0;
                o_cr        <= pick_any ? cr[pick_idx]  : '0;
                o_ov        <= pick_any && ov[pick_idx];
                o_oe        <= pick_any && oe[pick_idx];
                o_rc        <= pick_any && rc[pick_idx];
            end
        end
    end

    assign bus.input_ready         = |idle_mask;
    assign bus.output_valid        = out_valid_q;
    assign bus.rs_id_out           = o_tag;
    assign bus.result_reg_addr_out = o_gpr;
    assign bus.result              = o_res;
    assign bus.ov_out              = o_ov;
    assign bus.oe_out              = o_oe;
    assign bus.rc_out              = o_rc;
    assign bus.cr_lt               = o_cr[2];
    assign bus.cr_gt               = o_cr[1];
    assign bus.cr_eq               = o_cr[0];
endmodule

// File: doc/div_cluster.md
Name: div_cluster

Overview:
- Parametrised successor to the single divide unit behind the DIV reservation station.
- Holds ENGINES independent iterative radix-2 divide engines and accepts one new divide per cycle while any engine is free.
- Returns results out of order, tagged with the RS id and destination GPR, through one ready/valid result port.
- Sits between the DIV reservation station output and the result/CDB arbiter.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 4.
- ENGINES, 2, number of parallel divide engines, 1..8.
- RS_ID_WIDTH, 5, width of the reservation-station id tag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- input_valid  in  1  new divide offered
- input_ready  out  1  at least one engine IDLE
- rs_id_in  in  RS_ID_WIDTH  tag of the offered instruction
- result_reg_addr_in  in  5  destination GPR
- op1  in  WIDTH  dividend
- op2  in  WIDTH  divisor
- is_signed  in  1  1 = divw semantics, 0 = divwu
- oe_in  in  1  overflow-enable, passed through
- rc_in  in  1  record bit, passed through
- output_valid  out  1  result available
- output_ready  in  1  consumer accepts result
- rs_id_out  out  RS_ID_WIDTH  tag of the returned result
- result_reg_addr_out  out  5  destination GPR of the returned result
- result  out  WIDTH  quotient
- ov_out  out  1  divide-by-zero or signed overflow
- oe_out  out  1  oe_in of the returned op
- rc_out  out  1  rc_in of the returned op
- cr_lt, cr_gt, cr_eq  out  1 each  signed compare of result against 0

Behaviour:
- Reset (async, active-high): all engines IDLE; RR pointer 0; selection unlocked. Outputs: input_ready=1, output_valid=0, all data outputs 0.
- Per-engine FSM: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- Dispatch: an input handshake (input_valid && input_ready) loads the lowest-index IDLE engine with operands, tag, GPR, is_signed, oe and rc; that engine moves to PREP.
  - input_ready is derived only from registered engine states.
  - An engine freed by an output handshake is IDLE from the next cycle; no same-edge reuse.
- PREP (1 cycle):
  - Latch absolute values when is_signed, else the raw operands.
  - Record quotient sign = sign(op1) XOR sign(op2).
  - Flag ov if op2 == 0, or if is_signed and op1 == 0x80..0 and op2 == all-ones.
- ITER (exactly WIDTH cycles): restoring shift-subtract, one quotient bit per cycle, MSB first. The iteration counter runs WIDTH-1 down to 0.
- FIX (1 cycle):
  - Negate the quotient if the sign bit is set and is_signed.
  - If ov: result = 0 and ov_out = 1.
  - Compute cr_lt/gt/eq from the final result treated as signed.
- DONE: the engine holds all fields until granted.
- Latency: output_valid can first rise WIDTH+3 cycles after the accepting edge (35 for WIDTH=32), assuming no contention.
- Output arbitration:
  - Round-robin over DONE engines, starting at the RR pointer.
  - While output_valid && !output_ready, the selection is locked and all outputs are held stable, even if other engines reach DONE.
  - On handshake: the granted engine goes IDLE; RR pointer = granted index + 1 (mod ENGINES); lock released.
- Simultaneous input and output handshakes in the same cycle are legal and independent.
- Full: all engines busy -> input_ready=0; an offered op waits at the input port.
- Reset mid-operation aborts all engines; no result is emitted.

Optional Feature:
- DIV_EARLY_OUT_EN defined:
  - PREP goes directly to FIX when ov is set or |op1| < |op2|; the quotient is 0 in the non-ov case.
  - Latency for these cases is 3 cycles from accept to output_valid.
  - All other cases are unchanged.
- Undefined: every op takes the full WIDTH+3 cycles.

Test Plan:
- WIDTH=32, ENGINES=2: op1=100, op2=7, unsigned, tag 3 -> after 35 cycles result=14, tag 3, cr_gt=1, ov_out=0.
- Signed op1=-100, op2=7 -> result=0xFFFFFFF2 (-14), cr_lt=1; op1=0x80000000, op2=0xFFFFFFFF signed -> result=0, ov_out=1, cr_eq=1.
- op2=0, oe_in=1, rc_in=1 -> result=0, ov_out=1, oe_out=1, rc_out=1. With DIV_EARLY_OUT_EN, output_valid rises 3 cycles after accept.
- Three back-to-back offers, ids 1, 2, 3 -> ids 1 and 2 accepted on consecutive cycles; input_ready=0 until id 1 is drained; id 3 is accepted the cycle after id 1's output handshake.
- Hold output_ready=0 for 10 cycles with both engines DONE -> output_valid stays 1 and rs_id_out/result are stable. Release -> both results delivered in RR order: engine 0, then engine 1.
- Assert rst in the middle of ITER -> outputs return to reset values immediately; after release, a new op 50/5 returns 10.
